// File: rtl/multi_tap_echo.sv
// multi_tap_echo: NUM_TAPS echo taps read from one circular buffer, summed with the dry sample, with feedback writeback.
// Optional build macro ECHO_CLIP_CNT_EN adds a saturating clip_count output.
module multi_tap_echo #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 12,
  parameter int NUM_TAPS = 2,
  parameter int GAIN_W   = 6
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         in_valid,
  input  logic signed [DATA_W-1:0]     in_data,
  input  logic [NUM_TAPS*ADDR_W-1:0]   tap_delay,
  input  logic [NUM_TAPS*GAIN_W-1:0]   tap_gain,
  input  logic [GAIN_W-1:0]            fb_gain,
  output logic                         out_valid,
  output logic signed [DATA_W-1:0]     out_data,
  output logic                         busy,
  output logic                         overrun
`ifdef ECHO_CLIP_CNT_EN
  ,
  output logic [15:0]                  clip_count
`endif
);

  localparam int DEPTH  = 1 << ADDR_W;
  localparam int ACC_W  = DATA_W + GAIN_W + 4;
  localparam int PROD_W = DATA_W + GAIN_W + 1;
  localparam int K_W    = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;
  localparam logic signed [ACC_W-1:0] S_MAX = ACC_W'((1 << (DATA_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] S_MIN = -S_MAX - ACC_W'(1);

  typedef enum logic [1:0] {IDLE, RD, DRAIN, WR} state_e;

  state_e                    state_q, state_d;
  logic [K_W-1:0]            k_q, k_d;
  logic signed [DATA_W-1:0]  x_q, x_d;
  logic [ADDR_W-1:0]         delay_q [NUM_TAPS];
  logic [ADDR_W-1:0]         delay_d [NUM_TAPS];
  logic [GAIN_W-1:0]         gain_q  [NUM_TAPS];
  logic [GAIN_W-1:0]         gain_d  [NUM_TAPS];
  logic [GAIN_W-1:0]         fb_q, fb_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic [ADDR_W-1:0]         wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]           fill_q, fill_d;
  logic                      rd_ok_q, rd_ok_d;
  logic [GAIN_W-1:0]         rd_gain_q, rd_gain_d;
  logic                      out_valid_q, out_valid_d;
  logic signed [DATA_W-1:0]  out_data_q, out_data_d;
  logic                      overrun_q, overrun_d;

  logic signed [DATA_W-1:0]  mem [DEPTH];
  logic signed [DATA_W-1:0]  rd_data_q;
  logic [ADDR_W-1:0]         rd_addr_d;

  logic signed [PROD_W-1:0]  tap_prod, fb_prod;
  logic signed [ACC_W-1:0]   tap_term, mix_sum, wr_sum;
  logic signed [DATA_W-1:0]  tap_sat, wr_data;

  function automatic logic signed [DATA_W-1:0] sat(input logic signed [ACC_W-1:0] v);
    if (v > S_MAX)      return {1'b0, {(DATA_W-1){1'b1}}};
    else if (v < S_MIN) return {1'b1, {(DATA_W-1){1'b0}}};
    else                return v[DATA_W-1:0];
  endfunction

  // Tap k's address goes out in RD cycle k; its data, gain and validity arrive one cycle later.
  assign rd_addr_d = wr_ptr_q - delay_q[k_q];
  assign tap_prod  = $signed({1'b0, rd_gain_q}) * rd_data_q;
  assign tap_term  = rd_ok_q ? ACC_W'(tap_prod >>> GAIN_W) : '0;

  assign mix_sum   = ACC_W'(x_q) + acc_q;
  assign tap_sat   = sat(acc_q);
  assign fb_prod   = $signed({1'b0, fb_q}) * tap_sat;
  assign wr_sum    = ACC_W'(x_q) + ACC_W'(fb_prod >>> GAIN_W);
  assign wr_data   = sat(wr_sum);

  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    state_d     = state_q;
    k_d         = k_q;
    x_d         = x_q;
    delay_d     = delay_q;
    gain_d      = gain_q;
    fb_d        = fb_q;
    acc_d       = acc_q;
    wr_ptr_d    = wr_ptr_q;
    fill_d      = fill_q;
    rd_ok_d     = rd_ok_q;
    rd_gain_d   = rd_gain_q;
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;
    overrun_d   = in_valid && (state_q != IDLE);

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          x_d  = in_data;
          fb_d = fb_gain;
          for (int i = 0; i < NUM_TAPS; i++) begin
            delay_d[i] = tap_delay[i*ADDR_W +: ADDR_W];
            if (delay_d[i] == '0) delay_d[i] = ADDR_W'(1);
            gain_d[i] = tap_gain[i*GAIN_W +: GAIN_W];
          end
          acc_d   = '0;
          k_d     = '0;
          state_d = RD;
        end
      end
      RD: begin
        if (k_q != '0) acc_d = acc_q + tap_term;
        // A location farther back than the number of writes since reset holds stale RAM.
        rd_ok_d   = ({1'b0, delay_q[k_q]} <= fill_q);
        rd_gain_d = gain_q[k_q];
        if (k_q == K_W'(NUM_TAPS - 1)) state_d = DRAIN;
        else                           k_d     = k_q + 1'b1;
      end
      DRAIN: begin
        acc_d   = acc_q + tap_term;
        state_d = WR;
      end
      WR: begin
        wr_ptr_d    = wr_ptr_q + 1'b1;
        if (fill_q != (ADDR_W+1)'(DEPTH)) fill_d = fill_q + 1'b1;
        out_valid_d = 1'b1;
        out_data_d  = sat(mix_sum);
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      k_q         <= '0;
      x_q         <= '0;
      delay_q     <= '{default: '0};
      gain_q      <= '{default: '0};
      fb_q        <= '0;
      acc_q       <= '0;
      wr_ptr_q    <= '0;
      fill_q      <= '0;
      rd_ok_q     <= 1'b0;
      rd_gain_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      x_q         <= x_d;
      delay_q     <= delay_d;
      gain_q      <= gain_d;
      fb_q        <= fb_d;
      acc_q       <= acc_d;
      wr_ptr_q    <= wr_ptr_d;
      fill_q      <= fill_d;
      rd_ok_q     <= rd_ok_d;
      rd_gain_q   <= rd_gain_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      overrun_q   <= overrun_d;
    end
  end

  // NOTE: the buffer RAM is deliberately not reset; fill_q tells valid entries from stale ones.
  // The write enable comes from state_q, which reset clears, so a reset during WR suppresses the write.
  always_ff @(posedge clk) begin
    if (state_q == WR) mem[wr_ptr_q] <= wr_data;
    rd_data_q <= mem[rd_addr_d];
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign busy      = (state_q != IDLE);
  assign overrun   = overrun_q;

`ifdef ECHO_CLIP_CNT_EN
  logic        out_clip;
  logic [15:0] clip_cnt_q, clip_cnt_d;

  assign out_clip = (mix_sum > S_MAX) || (mix_sum < S_MIN);

  always_comb begin
    clip_cnt_d = clip_cnt_q;
    if ((state_q == WR) && out_clip && (clip_cnt_q != 16'hFFFF)) clip_cnt_d = clip_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) clip_cnt_q <= '0;
    else          clip_cnt_q <= clip_cnt_d;
  end

  assign clip_count = clip_cnt_q;
`endif

endmodule

// File: tb/tb_multi_tap_echo.sv
// Scoreboard bench for multi_tap_echo: a sample-history model pushes expected outputs and
// overrun pulses into queues; an independent monitor pops and compares them.
module tb_multi_tap_echo;
  localparam int DATA_W   = 16;
  localparam int ADDR_W   = 4;
  localparam int NUM_TAPS = 2;
  localparam int GAIN_W   = 6;
  localparam int LAT      = NUM_TAPS + 2;  // accept edge -> out_valid edge
  localparam int GAP      = NUM_TAPS + 3;  // accept edge -> next acceptable edge

  logic                        clk = 1'b0;
  logic                        reset_n = 1'b0;
  logic                        in_valid = 1'b0;
  logic signed [DATA_W-1:0]    in_data = '0;
  logic [NUM_TAPS*ADDR_W-1:0]  tap_delay = '0;
  logic [NUM_TAPS*GAIN_W-1:0]  tap_gain = '0;
  logic [GAIN_W-1:0]           fb_gain = '0;
  logic                        out_valid;
  logic signed [DATA_W-1:0]    out_data;
  logic                        busy;
  logic                        overrun;
`ifdef ECHO_CLIP_CNT_EN
  logic [15:0]                 clip_count;
`endif

  multi_tap_echo #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_TAPS(NUM_TAPS), .GAIN_W(GAIN_W)
  ) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_data(in_data),
    .tap_delay(tap_delay), .tap_gain(tap_gain), .fb_gain(fb_gain),
    .out_valid(out_valid), .out_data(out_data), .busy(busy), .overrun(overrun)
`ifdef ECHO_CLIP_CNT_EN
    , .clip_count(clip_count)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct { int data; int cyc; } exp_t;
  exp_t exp_q[$];
  int   ov_q[$];
  int   hist[$];
  int   total = 0;
  int   bad = 0;
  int   last_acc = -1000;
  int   clip_m = 0;
  int   cfg_d[NUM_TAPS];
  int   cfg_g[NUM_TAPS];
  int   cfg_fb = 0;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic int sat16(input int v);
    if (v > 32767)  return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  task automatic set_cfg(input int d0, input int g0, input int d1, input int g1, input int fb);
    cfg_d[0] = d0; cfg_g[0] = g0; cfg_d[1] = d1; cfg_g[1] = g1; cfg_fb = fb;
    tap_delay = {4'(d1), 4'(d0)};
    tap_gain  = {6'(g1), 6'(g0)};
    fb_gain   = 6'(fb);
  endtask

  // Reference: hist holds every value written to the buffer, newest last; a delay d reads
  // the entry written d samples ago, or 0 if fewer than d samples were ever written.
  task automatic model_issue(input int x, input int e);
    int tap_sum, d, s, raw;
    if (e - last_acc < GAP) begin
      ov_q.push_back(e);
      return;
    end
    last_acc = e;
    tap_sum = 0;
    for (int k = 0; k < NUM_TAPS; k++) begin
      d = (cfg_d[k] == 0) ? 1 : cfg_d[k];
      s = (d <= hist.size()) ? hist[hist.size() - d] : 0;
      tap_sum += (cfg_g[k] * s) >>> GAIN_W;
    end
    raw = x + tap_sum;
    if (raw != sat16(raw)) clip_m++;
    exp_q.push_back('{data: sat16(raw), cyc: e + LAT});
    hist.push_back(sat16(x + ((cfg_fb * sat16(tap_sum)) >>> GAIN_W)));
  endtask

  // Called at a negedge; drives one cycle and returns at the following negedge.
  task automatic step(input bit v, input int x);
    in_valid = v;
    in_data  = 16'(x);
    if (v) model_issue(x, cyc + 1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 0);
  endtask

  task automatic send(input int x);
    step(1'b1, x);
    idle(GAP);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 100 && exp_q.size() > 0; i++) @(negedge clk);
    idle(2);
    check("pending_out", exp_q.size(), 0);
    check("pending_overrun", ov_q.size(), 0);
  endtask

  task automatic do_reset(input int hold);
    in_valid = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_busy", busy, 0);
    check("rst_overrun", overrun, 0);
`ifdef ECHO_CLIP_CNT_EN
    check("rst_clip_count", clip_count, 0);
`endif
    repeat (hold) @(negedge clk);
    hist.delete();
    exp_q.delete();
    ov_q.delete();
    last_acc = -1000;
    clip_m = 0;
    reset_n = 1'b1;
  endtask

  // Monitor: compares every output strobe and overrun pulse against the scoreboard.
  always @(negedge clk) begin
    if (reset_n) begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_out_valid: got data %0d expected no output (cycle %0d)", out_data, cyc);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("out_data", int'(out_data), e.data);
          check("out_latency_cycle", cyc, e.cyc);
        end
      end
      if (overrun) begin
        if (ov_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_overrun: got pulse expected none (cycle %0d)", cyc);
        end else begin
          check("overrun_cycle", cyc, ov_q.pop_front());
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    set_cfg(0, 0, 0, 0, 0);
    @(negedge clk);
    do_reset(2);

    // Impulse through tap 0.
    set_cfg(3, 32, 7, 0, 0);
    step(1'b1, 1000);
    check("busy_after_accept", busy, 1);
    idle(GAP);
    for (int i = 0; i < 4; i++) send(0);
    wait_drain();

    // Empty buffer: taps reaching past the written history contribute 0.
    do_reset(2);
    set_cfg(5, 63, 9, 0, 0);
    send(700);
    send(700);
    wait_drain();

    // Feedback decay.
    do_reset(2);
    set_cfg(2, 32, 1, 0, 32);
    send(1024);
    for (int i = 0; i < 7; i++) send(0);
    wait_drain();

    // Saturation both directions.
    do_reset(2);
    set_cfg(1, 63, 1, 0, 0);
    send(30000);
    send(30000);
    wait_drain();
`ifdef ECHO_CLIP_CNT_EN
    check("clip_count_pos", clip_count, clip_m);
`endif
    do_reset(2);
    send(-30000);
    send(-30000);
    wait_drain();

    // Back-to-back in_valid, then a long delay across the pointer wrap.
    do_reset(2);
    set_cfg(1, 32, 1, 0, 0);
    step(1'b1, 10);
    step(1'b1, 20);
    idle(GAP);
    set_cfg(15, 32, 3, 0, 0);
    for (int i = 0; i < 20; i++) send(100 * (i + 1));
    wait_drain();

    // Reset while reading taps: the in-flight sample must vanish.
    step(1'b1, 555);
    idle(1);
    check("busy_mid_sample", busy, 1);
    do_reset(2);
    set_cfg(5, 63, 9, 0, 0);
    send(700);
    send(700);
    wait_drain();

    // Randomised configs, samples and spacing (short gaps provoke overruns).
    for (int i = 0; i < 300; i++) begin
      set_cfg($urandom_range(0, 15), $urandom_range(0, 63),
              $urandom_range(0, 15), $urandom_range(0, 63), $urandom_range(0, 63));
      step(1'b1, int'($urandom_range(0, 65535)) - 32768);
      idle($urandom_range(0, 6));
    end
    wait_drain();
`ifdef ECHO_CLIP_CNT_EN
    check("clip_count_random", clip_count, clip_m);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
